// File: rtl/ram_dp_be.sv
// ram_dp_be: dual-port byte-enable RAM for the cache data/tag arrays.
//   Port A is read/write, port B is read-only. After reset a sweep writes zero to every word,
//   one word per cycle; requests are accepted only once the sweep has finished.
// Ports:
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   o_ready               1 = clear sweep done, requests accepted
//   a_en/a_wen/a_ben      port A request, write select, byte enables
//   a_addr/a_wdata        port A byte address and write data
//   a_rdata/a_rvalid      port A read data and single-cycle valid pulse
//   b_en/b_addr           port B read request and byte address
//   b_rdata/b_rvalid      port B read data and single-cycle valid pulse
//   o_misalign            sticky flag: an accepted request had non-zero low address bits
module ram_dp_be #(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BYTES        = DATA_WIDTH / 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RDW_MODE     = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  o_ready,
    input  logic                  a_en,
    input  logic                  a_wen,
    input  logic [BYTES-1:0]      a_ben,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  o_misalign
);

    localparam int unsigned AL    = $clog2(BYTES);
    localparam int unsigned IDX_W = ADDR_WIDTH - AL;
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StRun   = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] a_idx, b_idx;
    logic             ready, a_mis, b_mis;
    logic             a_wr, a_rd, b_rd, clr_we;

    assign ready   = (state_q == StRun);
    assign o_ready = ready;

    // Low address bits select nothing: the word index is the floor-aligned address.
    assign a_idx = IDX_W'(a_addr >> AL);
    assign b_idx = IDX_W'(b_addr >> AL);
    assign a_mis = |(a_addr & LOW_MASK);
    assign b_mis = |(b_addr & LOW_MASK);

    // Misaligned writes are dropped entirely; misaligned reads still return the aligned word.
    assign a_wr   = ready & a_en & a_wen & ~a_mis;
    assign a_rd   = ready & a_en & ~a_wen;
    assign b_rd   = ready & b_en;
    assign clr_we = reset_n & (state_q == StClear);

    // Clear sweep FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == StClear) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage: sweep writes and port A byte-lane writes never overlap (sweep implies not ready).
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr_q] <= '0;
        end else if (a_wr) begin
            for (int n = 0; n < BYTES; n++) begin
                if (a_ben[n]) begin
                    mem[a_idx][8*n +: 8] <= a_wdata[8*n +: 8];
                end
            end
        end
    end

    // Read words; B optionally sees the same-cycle A write merged into the old word.
    logic [DATA_WIDTH-1:0] a_word, b_word;

    always_comb begin
        a_word = mem[a_idx];
        b_word = mem[b_idx];
        if ((RDW_MODE == 1) && a_wr && (a_idx == b_idx)) begin
            for (int n = 0; n < BYTES; n++) begin
                if (a_ben[n]) begin
                    b_word[8*n +: 8] = a_wdata[8*n +: 8];
                end
            end
        end
    end

    // First read stage; data registers only load on an accepted read so they hold otherwise.
    logic                  a_s0_v_q, b_s0_v_q, misalign_q;
    logic [DATA_WIDTH-1:0] a_s0_data_q, b_s0_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_s0_v_q    <= 1'b0;
            b_s0_v_q    <= 1'b0;
            a_s0_data_q <= '0;
            b_s0_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            a_s0_v_q <= a_rd;
            b_s0_v_q <= b_rd;
            if (a_rd) begin
                a_s0_data_q <= a_word;
            end
            if (b_rd) begin
                b_s0_data_q <= b_word;
            end
            misalign_q <= misalign_q | (ready & ((a_en & a_mis) | (b_en & b_mis)));
        end
    end

    assign o_misalign = misalign_q;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  a_v_q, b_v_q;
        logic [DATA_WIDTH-1:0] a_d_q, b_d_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                a_v_q <= 1'b0;
                b_v_q <= 1'b0;
                a_d_q <= '0;
                b_d_q <= '0;
            end else begin
                a_v_q <= a_s0_v_q;
                b_v_q <= b_s0_v_q;
                if (a_s0_v_q) begin
                    a_d_q <= a_s0_data_q;
                end
                if (b_s0_v_q) begin
                    b_d_q <= b_s0_data_q;
                end
            end
        end

        assign a_rvalid = a_v_q;
        assign a_rdata  = a_d_q;
        assign b_rvalid = b_v_q;
        assign b_rdata  = b_d_q;
    end else begin : g_lat1
        assign a_rvalid = a_s0_v_q;
        assign a_rdata  = a_s0_data_q;
        assign b_rvalid = b_s0_v_q;
        assign b_rdata  = b_s0_data_q;
    end

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: drives two ram_dp_be instances with identical stimulus.
//   dut1: READ_LATENCY=1, RDW_MODE=0; dut2: READ_LATENCY=2, RDW_MODE=1.
//   Reads push expected data and due cycle into per-port queues; a negedge monitor pops them.
module tb_ram_dp_be;

    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        a_en, a_wen, b_en;
    logic [3:0]  a_ben;
    logic [6:0]  a_addr, b_addr;
    logic [31:0] a_wdata;

    logic        rdy1, a_rvalid1, b_rvalid1, mis1;
    logic        rdy2, a_rvalid2, b_rvalid2, mis2;
    logic [31:0] a_rdata1, b_rdata1, a_rdata2, b_rdata2;

    ram_dp_be #(.READ_LATENCY(1), .RDW_MODE(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .o_ready(rdy1),
        .a_en(a_en), .a_wen(a_wen), .a_ben(a_ben), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .o_misalign(mis1)
    );

    ram_dp_be #(.READ_LATENCY(2), .RDW_MODE(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .o_ready(rdy2),
        .a_en(a_en), .a_wen(a_wen), .a_ben(a_ben), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata2), .b_rvalid(b_rvalid2),
        .o_misalign(mis2)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t qa1[$], qa2[$], qb1[$], qb2[$];
    logic [31:0] model [DEPTH];
    int  cyc = 0;
    int  n_err = 0;
    int  n_checks = 0;
    bit  mon_en = 1'b0;
    bit  dn;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic v, input logic [31:0] d,
                            input bit due, input logic [31:0] exp);
        chk({tag, "_rvalid"}, 32'(v), 32'(due));
        if (due) chk({tag, "_rdata"}, d, exp);
    endtask

    // Scoreboard monitor: rvalid must pulse exactly on the due cycle of the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            dn = (qa1.size() != 0) && (qa1[0].due == cyc);
            chk_port("a1", a_rvalid1, a_rdata1, dn, dn ? qa1[0].data : 32'h0);
            if (dn) void'(qa1.pop_front());
            dn = (qa2.size() != 0) && (qa2[0].due == cyc);
            chk_port("a2", a_rvalid2, a_rdata2, dn, dn ? qa2[0].data : 32'h0);
            if (dn) void'(qa2.pop_front());
            dn = (qb1.size() != 0) && (qb1[0].due == cyc);
            chk_port("b1", b_rvalid1, b_rdata1, dn, dn ? qb1[0].data : 32'h0);
            if (dn) void'(qb1.pop_front());
            dn = (qb2.size() != 0) && (qb2[0].due == cyc);
            chk_port("b2", b_rvalid2, b_rdata2, dn, dn ? qb2[0].data : 32'h0);
            if (dn) void'(qb2.pop_front());
        end
    end

    // One cycle of stimulus; acc says whether the bench expects the request to be accepted.
    task automatic drive(input logic ae, input logic aw, input logic [3:0] ab,
                         input logic [6:0] aa, input logic [31:0] ad,
                         input logic be, input logic [6:0] ba, input bit acc);
        logic [31:0] pre, mrg;
        @(posedge clk);
        #1;
        a_en = ae; a_wen = aw; a_ben = ab; a_addr = aa; a_wdata = ad;
        b_en = be; b_addr = ba;
        if (acc) begin
            if (be) begin
                pre = model[ba[6:2]];
                mrg = pre;
                if (ae && aw && aa[1:0] == 2'b00 && aa[6:2] == ba[6:2]) begin
                    for (int n = 0; n < 4; n++) if (ab[n]) mrg[8*n +: 8] = ad[8*n +: 8];
                end
                qb1.push_back('{data: pre, due: cyc + 1});
                qb2.push_back('{data: mrg, due: cyc + 2});
            end
            if (ae && !aw) begin
                qa1.push_back('{data: model[aa[6:2]], due: cyc + 1});
                qa2.push_back('{data: model[aa[6:2]], due: cyc + 2});
            end
            if (ae && aw && aa[1:0] == 2'b00) begin
                for (int n = 0; n < 4; n++) if (ab[n]) model[aa[6:2]][8*n +: 8] = ad[8*n +: 8];
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'h0, 7'h00, 32'h0, 1'b0, 7'h00, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready1"}, 32'(rdy1), 32'h0);
        chk({tag, "_ready2"}, 32'(rdy2), 32'h0);
        chk({tag, "_mis1"}, 32'(mis1), 32'h0);
        chk({tag, "_mis2"}, 32'(mis2), 32'h0);
        chk({tag, "_ardata1"}, a_rdata1, 32'h0);
        chk({tag, "_brdata1"}, b_rdata1, 32'h0);
        chk({tag, "_ardata2"}, a_rdata2, 32'h0);
        chk({tag, "_brdata2"}, b_rdata2, 32'h0);
    endtask

    // Called just after the reset-release edge: o_ready must rise after exactly DEPTH edges.
    // The request in the last not-ready cycle must be dropped (no write, no rvalid).
    task automatic sweep_ready();
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == DEPTH - 1) drive(1'b1, 1'b1, 4'hF, 7'h00, 32'hFFFFFFFF, 1'b1, 7'h00, 1'b0);
            else                idle(1);
            @(negedge clk);
            chk($sformatf("ready1_c%0d", i), 32'(rdy1), 32'(i == DEPTH));
            chk($sformatf("ready2_c%0d", i), 32'(rdy2), 32'(i == DEPTH));
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 4'h0, 7'(i * 4), 32'h0, 1'b1, 7'((DEPTH - 1 - i) * 4), 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        a_en = 1'b0; a_wen = 1'b0; a_ben = 4'h0; a_addr = 7'h0; a_wdata = 32'h0;
        b_en = 1'b0; b_addr = 7'h0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check_reset_state("rst0");

        // Sweep after reset, then every word reads zero on both ports.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sweep_ready();
        read_all();
        idle(3);

        // Full write, partial write, read back one cycle later.
        drive(1'b1, 1'b1, 4'b1111, 7'h08, 32'hDEADBEEF, 1'b0, 7'h00, 1'b1);
        drive(1'b1, 1'b1, 4'b0101, 7'h08, 32'h11223344, 1'b0, 7'h00, 1'b1);
        drive(1'b1, 1'b0, 4'b0000, 7'h08, 32'h0, 1'b0, 7'h00, 1'b1);

        // Read-during-write collision on word 0x10, then readback on both ports.
        drive(1'b1, 1'b1, 4'b1111, 7'h10, 32'h12345678, 1'b0, 7'h00, 1'b1);
        drive(1'b1, 1'b1, 4'b0011, 7'h10, 32'h0000AAAA, 1'b1, 7'h10, 1'b1);
        drive(1'b1, 1'b0, 4'b0000, 7'h10, 32'h0, 1'b1, 7'h10, 1'b1);
        // ben=0 write is a no-op.
        drive(1'b1, 1'b1, 4'b0000, 7'h10, 32'hFFFFFFFF, 1'b0, 7'h00, 1'b1);
        drive(1'b1, 1'b0, 4'b0000, 7'h10, 32'h0, 1'b0, 7'h00, 1'b1);

        // Back-to-back B reads, ordered pulses at both latencies.
        drive(1'b0, 1'b0, 4'h0, 7'h00, 32'h0, 1'b1, 7'h00, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 7'h00, 32'h0, 1'b1, 7'h04, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 7'h00, 32'h0, 1'b1, 7'h08, 1'b1);
        idle(3);

        // Misaligned write dropped; misaligned read returns the aligned word; sticky flag.
        @(negedge clk);
        chk("mis1_before", 32'(mis1), 32'h0);
        chk("mis2_before", 32'(mis2), 32'h0);
        drive(1'b1, 1'b1, 4'b1111, 7'h0A, 32'hFFFFFFFF, 1'b0, 7'h00, 1'b1);
        @(negedge clk);
        chk("mis1_not_yet", 32'(mis1), 32'h0);
        drive(1'b1, 1'b0, 4'b0000, 7'h08, 32'h0, 1'b1, 7'h0B, 1'b1);
        @(negedge clk);
        chk("mis1_set", 32'(mis1), 32'h1);
        chk("mis2_set", 32'(mis2), 32'h1);
        idle(5);
        @(negedge clk);
        chk("mis1_sticky", 32'(mis1), 32'h1);
        chk("mis2_sticky", 32'(mis2), 32'h1);

        // Reset in RUN clears outputs and flag; then reset again mid-sweep at ptr=10.
        idle(3);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_state("rst1");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(10);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sweep_ready();
        read_all();
        idle(3);

        chk("sb_empty", 32'(qa1.size() + qa2.size() + qb1.size() + qb2.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
